// File: rtl/id_stage_regfile_datapath_if.sv
// Decode-stage bus: register-file controls, addresses and data, branch offsets, and pass-throughs.
// The master side drives the decode inputs. The slave side is the datapath that returns read data and offsets.
interface id_stage_regfile_datapath_if;
  logic        RegWrite;
  logic        Reg2Loc;
  logic        BLsignal;
  logic        UnCondBr;
  logic        update;
  logic [4:0]  Rn;
  logic [4:0]  Rm;
  logic [4:0]  Rd;
  logic [63:0] WBsignal;
  logic [63:0] BLT;
  logic [63:0] pc_if;
  logic [18:0] COND_BR_addr;
  logic [25:0] BR_addr;
  logic [63:0] Da;
  logic [63:0] Db;
  logic [63:0] BR_to_shift;
  logic [63:0] pc_id;
  logic        update_flags;

  modport master (
    output RegWrite, Reg2Loc, BLsignal, UnCondBr, update,
    output Rn, Rm, Rd, WBsignal, BLT, pc_if, COND_BR_addr, BR_addr,
    input  Da, Db, BR_to_shift, pc_id, update_flags
  );

  modport slave (
    input  RegWrite, Reg2Loc, BLsignal, UnCondBr, update,
    input  Rn, Rm, Rd, WBsignal, BLT, pc_if, COND_BR_addr, BR_addr,
    output Da, Db, BR_to_shift, pc_id, update_flags
  );
endinterface

// File: rtl/id_stage_regfile_datapath.sv
// LEGv8 decode-stage datapath: 32x64 register file (X31 = XZR) with asynchronous reads,
// port-B and write-data muxes, branch-offset sign extension, and PC/flag pass-through.
module id_stage_regfile_datapath (
  input logic                          clk,
  input logic                          reset,
  id_stage_regfile_datapath_if.slave   bus
);

  localparam logic [4:0] XZR = 5'd31;

  // Only X0..X30 have storage. XZR is decoded on the read side.
  logic [63:0] regs [0:30];
  logic [63:0] dw;
  logic [4:0]  ab;

  assign dw = bus.BLsignal ? bus.BLT : bus.WBsignal;
  assign ab = bus.Reg2Loc  ? bus.Rd  : bus.Rm;

  // NOTE: every entry is cleared on reset because software expects a zeroed
  // register file. This prevents the array from mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) regs[i] <= '0;
    end else if (bus.RegWrite && (bus.Rd != XZR)) begin
      regs[bus.Rd] <= dw;
    end
  end

  // No write bypass: a register being written reads its old value until the edge.
  assign bus.Da = (bus.Rn == XZR) ? '0 : regs[bus.Rn];
  assign bus.Db = (ab     == XZR) ? '0 : regs[ab];

  assign bus.BR_to_shift = bus.UnCondBr ? {{38{bus.BR_addr[25]}}, bus.BR_addr}
                                        : {{45{bus.COND_BR_addr[18]}}, bus.COND_BR_addr};

  assign bus.pc_id        = bus.pc_if;
  assign bus.update_flags = bus.update;

endmodule

// File: tb/tb_id_stage_regfile_datapath.sv
// Directed testbench for id_stage_regfile_datapath. It checks hand-computed values for reset,
// writes, XZR, the port-B mux, branch-offset sign extension and the pass-throughs.
module tb_id_stage_regfile_datapath;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  id_stage_regfile_datapath_if bus ();

  id_stage_regfile_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, so no input is near an active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [63:0] data);
    bus.RegWrite = 1'b1;
    bus.BLsignal = 1'b0;
    bus.Rd       = rd;
    bus.WBsignal = data;
    tick();
    bus.RegWrite = 1'b0;
  endtask

  initial begin
    reset            = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.Reg2Loc      = 1'b0;
    bus.BLsignal     = 1'b0;
    bus.UnCondBr     = 1'b0;
    bus.update       = 1'b0;
    bus.Rn           = '0;
    bus.Rm           = '0;
    bus.Rd           = '0;
    bus.WBsignal     = '0;
    bus.BLT          = '0;
    bus.pc_if        = '0;
    bus.COND_BR_addr = '0;
    bus.BR_addr      = '0;
    #2;

    // 1. Reset wins over a simultaneous write to X5. Afterwards every address reads 0.
    reset        = 1'b1;
    bus.RegWrite = 1'b1;
    bus.Rd       = 5'd5;
    bus.WBsignal = 64'hFFFF;
    tick();
    reset        = 1'b0;
    bus.RegWrite = 1'b0;
    bus.Reg2Loc  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.Rn = 5'(i);
      bus.Rm = 5'(i);
      #1;
      check($sformatf("reset_da_x%0d", i), bus.Da, 64'h0);
      check($sformatf("reset_db_x%0d", i), bus.Db, 64'h0);
    end

    // 2. A branch-link write selects BLT. The new value must not appear before the edge.
    bus.RegWrite = 1'b1;
    bus.BLsignal = 1'b1;
    bus.BLT      = 64'd69;
    bus.WBsignal = 64'hDEAD;
    bus.Rd       = 5'd8;
    bus.Rn       = 5'd8;
    bus.Reg2Loc  = 1'b1;
    #1;
    check("bl_no_bypass_da", bus.Da, 64'h0);
    check("bl_no_bypass_db", bus.Db, 64'h0);
    tick();
    bus.RegWrite = 1'b0;
    bus.BLsignal = 1'b0;
    check("bl_da", bus.Da, 64'd69);
    check("bl_db", bus.Db, 64'd69);

    // 3. Normal writeback and the port-B address mux.
    write_reg(5'd3, 64'h1234);
    write_reg(5'd4, 64'h5678);
    bus.Rm      = 5'd3;
    bus.Rd      = 5'd4;
    bus.Reg2Loc = 1'b0;
    #1;
    check("mux_rm_db", bus.Db, 64'h1234);
    bus.Reg2Loc = 1'b1;
    #1;
    check("mux_rd_db", bus.Db, 64'h5678);
    bus.RegWrite = 1'b0;
    bus.Rd       = 5'd3;
    bus.WBsignal = 64'hFFFF;
    tick();
    bus.Rn = 5'd3;
    #1;
    check("nowrite_x3", bus.Da, 64'h1234);

    // 4. Writes to XZR are discarded. Then a full sweep of X0..X30.
    write_reg(5'd31, 64'hAAAA);
    bus.Rn      = 5'd31;
    bus.Rm      = 5'd31;
    bus.Reg2Loc = 1'b0;
    #1;
    check("xzr_da", bus.Da, 64'h0);
    check("xzr_db", bus.Db, 64'h0);
    for (int i = 0; i < 31; i++) write_reg(5'(i), 64'(i + 100));
    for (int i = 0; i < 31; i++) begin
      bus.Rn = 5'(i);
      bus.Rm = 5'(i);
      #1;
      check($sformatf("sweep_da_x%0d", i), bus.Da, 64'(i + 100));
      check($sformatf("sweep_db_x%0d", i), bus.Db, 64'(i + 100));
    end

    // 5. Branch-offset sign extension at both widths.
    bus.UnCondBr     = 1'b0;
    bus.COND_BR_addr = 19'h7FFFF;
    #1;
    check("cond_neg", bus.BR_to_shift, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.COND_BR_addr = 19'h3FFFF;
    #1;
    check("cond_pos", bus.BR_to_shift, 64'h0000_0000_0003_FFFF);
    bus.UnCondBr = 1'b1;
    bus.BR_addr  = 26'h2000000;
    #1;
    check("uncond_neg", bus.BR_to_shift, 64'hFFFF_FFFF_FE00_0000);
    bus.BR_addr = 26'd5;
    #1;
    check("uncond_pos", bus.BR_to_shift, 64'd5);
    bus.UnCondBr     = 1'b0;
    bus.COND_BR_addr = 19'h40000;
    #1;
    check("cond_sel_back", bus.BR_to_shift, 64'hFFFF_FFFF_FFFC_0000);

    // 6. Reset during a write clears X7 and everything else.
    // The pass-throughs need no clock.
    reset        = 1'b1;
    bus.RegWrite = 1'b1;
    bus.Rd       = 5'd7;
    bus.WBsignal = 64'h99;
    tick();
    reset        = 1'b0;
    bus.RegWrite = 1'b0;
    bus.Rn       = 5'd7;
    bus.Rm       = 5'd8;
    bus.Reg2Loc  = 1'b0;
    #1;
    check("rst_wr_x7", bus.Da, 64'h0);
    check("rst_x8", bus.Db, 64'h0);
    bus.pc_if  = 64'h400;
    bus.update = 1'b1;
    #1;
    check("pc_id", bus.pc_id, 64'h400);
    check("update_flags", 64'(bus.update_flags), 64'd1);
    bus.update = 1'b0;
    #1;
    check("update_flags_low", 64'(bus.update_flags), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
